// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access widths, load funct3
// codes, FSM state type and byte-lane helpers.
package mem_access_unit_pkg;

   localparam int BE_W = 4;

   // funct3[1:0] access size
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // full funct3 load encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_WB   = 3'd3,
      S_EXC  = 3'd4
   } mau_state_e;

   // Access is misaligned when the lane offset does not fit the access size.
   // Unused size code 11 is treated like a word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lane[0];
         default: mis = (lane != 2'b00);
      endcase
      return mis;
   endfunction

   // Byte enables for an aligned access of the given size at the given lane.
   function automatic logic [BE_W-1:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
      logic [BE_W-1:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lane;
         SZ_HALF: be = 4'b0011 << lane;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load-data formatter: picks the byte/half at the addressed
// lane and sign- or zero-extends it; words pass straight through.
module mem_access_unit_load_formatter
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      lane,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection followed by extension according to the load type.
   always_comb begin
      case (lane)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         default: byte_s = rdata[31:24];
      endcase
      half_s = lane[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   result = {{(XLEN-8){byte_s[7]}}, byte_s};
         F3_LH:   result = {{(XLEN-16){half_s[15]}}, half_s};
         F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_s};
         F3_LHU:  result = {{(XLEN-16){1'b0}}, half_s};
         F3_LW:   result = rdata;
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: accepts execute results, performs the data-memory
// req/gnt/rvalid transaction, formats loads and drives register writeback.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr_in,
   input  logic            reg_write_in,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [BE_W-1:0] dmem_be,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            reg_write_en,
   output logic            misaligned
);

   mau_state_e      state_q, state_d;
   logic [1:0]      lane_q, lane_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [4:0]      rd_q, rd_d;
   logic            rw_q, rw_d;
   logic            load_q, load_d;

   logic            ex_ready_q, ex_ready_d;
   logic            dmem_req_q, dmem_req_d;
   logic            dmem_we_q, dmem_we_d;
   logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
   logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
   logic [BE_W-1:0] dmem_be_q, dmem_be_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic [XLEN-1:0] rd_data_q, rd_data_d;
   logic            reg_write_en_q, reg_write_en_d;
   logic            misaligned_q, misaligned_d;

   logic [XLEN-1:0] load_fmt_s;
   logic [XLEN-1:0] store_data_s;
   logic            is_mem_s;
   logic            is_load_s;

   mem_access_unit_load_formatter #(.XLEN(XLEN)) u_load_formatter (
      .rdata  (dmem_rdata),
      .lane   (lane_q),
      .funct3 (funct3_q),
      .result (load_fmt_s)
   );

   // Store lane replication and op classification of the incoming operation.
   always_comb begin
      is_mem_s  = mem_read | mem_write;
      is_load_s = mem_read;
      case (funct3[1:0])
         SZ_BYTE: store_data_s = {(XLEN/8){rs2_data[7:0]}};
         SZ_HALF: store_data_s = {(XLEN/16){rs2_data[15:0]}};
         default: store_data_s = rs2_data;
      endcase
   end

   // Next-state and next-output computation; all outputs are registered.
   always_comb begin
      state_d        = state_q;
      lane_d         = lane_q;
      funct3_d       = funct3_q;
      rd_d           = rd_q;
      rw_d           = rw_q;
      load_d         = load_q;
      dmem_req_d     = 1'b0;
      dmem_we_d      = 1'b0;
      dmem_addr_d    = {XLEN{1'b0}};
      dmem_wdata_d   = {XLEN{1'b0}};
      dmem_be_d      = {BE_W{1'b0}};
      rd_addr_d      = rd_addr_q;
      rd_data_d      = rd_data_q;
      reg_write_en_d = 1'b0;
      misaligned_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ex_valid) begin
               lane_d   = alu_result[1:0];
               funct3_d = funct3;
               rd_d     = rd_addr_in;
               rw_d     = reg_write_in;
               load_d   = is_load_s;
               if (!is_mem_s) begin
                  state_d        = S_WB;
                  rd_addr_d      = rd_addr_in;
                  rd_data_d      = alu_result;
                  reg_write_en_d = reg_write_in && (rd_addr_in != 5'd0);
               end else if (is_misaligned(funct3[1:0], alu_result[1:0])) begin
                  state_d      = S_EXC;
                  misaligned_d = 1'b1;
               end else begin
                  state_d      = S_REQ;
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = !is_load_s;
                  dmem_addr_d  = {alu_result[XLEN-1:2], 2'b00};
                  dmem_wdata_d = is_load_s ? {XLEN{1'b0}} : store_data_s;
                  dmem_be_d    = lane_be(funct3[1:0], alu_result[1:0]);
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (dmem_gnt) begin
               state_d = load_q ? S_WAIT : S_IDLE;
            end else begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = dmem_we_q;
               dmem_addr_d  = dmem_addr_q;
               dmem_wdata_d = dmem_wdata_q;
               dmem_be_d    = dmem_be_q;
            end
         end
         S_WAIT: begin
            if (dmem_rvalid) begin
               state_d        = S_WB;
               rd_addr_d      = rd_q;
               rd_data_d      = load_fmt_s;
               reg_write_en_d = rw_q && (rd_q != 5'd0);
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WB:    state_d = S_IDLE;
         S_EXC:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ex_ready_d = (state_d == S_IDLE);
   end

   // State and output registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         lane_q         <= 2'b00;
         funct3_q       <= 3'b000;
         rd_q           <= 5'd0;
         rw_q           <= 1'b0;
         load_q         <= 1'b0;
         ex_ready_q     <= 1'b1;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= {XLEN{1'b0}};
         dmem_wdata_q   <= {XLEN{1'b0}};
         dmem_be_q      <= {BE_W{1'b0}};
         rd_addr_q      <= 5'd0;
         rd_data_q      <= {XLEN{1'b0}};
         reg_write_en_q <= 1'b0;
         misaligned_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         lane_q         <= lane_d;
         funct3_q       <= funct3_d;
         rd_q           <= rd_d;
         rw_q           <= rw_d;
         load_q         <= load_d;
         ex_ready_q     <= ex_ready_d;
         dmem_req_q     <= dmem_req_d;
         dmem_we_q      <= dmem_we_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_wdata_q   <= dmem_wdata_d;
         dmem_be_q      <= dmem_be_d;
         rd_addr_q      <= rd_addr_d;
         rd_data_q      <= rd_data_d;
         reg_write_en_q <= reg_write_en_d;
         misaligned_q   <= misaligned_d;
      end
   end

   assign ex_ready     = ex_ready_q;
   assign dmem_req     = dmem_req_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign dmem_be      = dmem_be_q;
   assign rd_addr      = rd_addr_q;
   assign rd_data      = rd_data_q;
   assign reg_write_en = reg_write_en_q;
   assign misaligned   = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] alu_result;
   logic [31:0] rs2_data;
   logic [4:0]  rd_addr_in;
   logic        reg_write_in;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        reg_write_en;
   logic        misaligned;

   int tests_run;
   int tests_failed;

   mem_access_unit #(.XLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .alu_result   (alu_result),
      .rs2_data     (rs2_data),
      .rd_addr_in   (rd_addr_in),
      .reg_write_in (reg_write_in),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .funct3       (funct3),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_be      (dmem_be),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .reg_write_en (reg_write_en),
      .misaligned   (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one clock; return 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ex_valid     = 1'b0;
      alu_result   = 32'h0;
      rs2_data     = 32'h0;
      rd_addr_in   = 5'd0;
      reg_write_in = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      funct3       = 3'b000;
      dmem_gnt     = 1'b0;
      dmem_rvalid  = 1'b0;
      dmem_rdata   = 32'h0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (ex_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ex_ready got %b want 1", ex_ready);
      end
      tests_run++;
      if ({dmem_req, dmem_we, dmem_be, reg_write_en, misaligned} !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_ctrl got %b want 00000000", {dmem_req, dmem_we, dmem_be, reg_write_en, misaligned});
      end
      tests_run++;
      if ({dmem_addr, dmem_wdata, rd_data, rd_addr} !== 101'h0) begin
         tests_failed++;
         $display("FAIL reset_data got %h %h %h %h want zeros", dmem_addr, dmem_wdata, rd_data, rd_addr);
      end
   endtask

   task automatic test_alu();
      ex_valid = 1'b1; alu_result = 32'h0000_0008; rd_addr_in = 5'd3; reg_write_in = 1'b1;
      tick();
      ex_valid = 1'b0;
      tests_run++;
      if ({reg_write_en, rd_addr, rd_data, dmem_req, ex_ready} !== {1'b1, 5'd3, 32'h8, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL alu_wb got rwe=%b rd=%0d data=%h req=%b rdy=%b want 1 3 00000008 0 0",
                  reg_write_en, rd_addr, rd_data, dmem_req, ex_ready);
      end
      tick();
      tests_run++;
      if ({reg_write_en, ex_ready, dmem_req} !== 3'b010) begin
         tests_failed++;
         $display("FAIL alu_after got rwe=%b rdy=%b req=%b want 0 1 0", reg_write_en, ex_ready, dmem_req);
      end
   endtask

   task automatic test_back_to_back();
      ex_valid = 1'b1; rd_addr_in = 5'd9; reg_write_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_result = 32'h0000_0100 + i;
         tick();
         tests_run++;
         if ({reg_write_en, rd_data, ex_ready} !== {1'b1, 32'h0000_0100 + i, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_wb%0d got rwe=%b data=%h rdy=%b want 1 %h 0", i, reg_write_en, rd_data, ex_ready, 32'h100 + i);
         end
         tick();
         tests_run++;
         if ({reg_write_en, ex_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_gap%0d got rwe=%b rdy=%b want 0 1", i, reg_write_en, ex_ready);
         end
      end
      ex_valid = 1'b0;
   endtask

   task automatic test_store();
      logic [31:0] addr_t  [3];
      logic [31:0] data_t  [3];
      logic [2:0]  f3_t    [3];
      logic [3:0]  be_t    [3];
      logic [31:0] wdata_t [3];
      addr_t[0] = 32'h0000_1002; data_t[0] = 32'h1234_56AB; f3_t[0] = 3'b000; be_t[0] = 4'b0100; wdata_t[0] = 32'hABAB_ABAB;
      addr_t[1] = 32'h0000_1002; data_t[1] = 32'h1234_5678; f3_t[1] = 3'b001; be_t[1] = 4'b1100; wdata_t[1] = 32'h5678_5678;
      addr_t[2] = 32'h0000_1004; data_t[2] = 32'hCAFE_F00D; f3_t[2] = 3'b010; be_t[2] = 4'b1111; wdata_t[2] = 32'hCAFE_F00D;
      for (int i = 0; i < 3; i++) begin
         ex_valid = 1'b1; alu_result = addr_t[i]; rs2_data = data_t[i]; funct3 = f3_t[i];
         mem_write = 1'b1; rd_addr_in = 5'd4; reg_write_in = 1'b0; dmem_gnt = 1'b1;
         tick();
         ex_valid = 1'b0; mem_write = 1'b0;
         tests_run++;
         if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ex_ready} !==
             {1'b1, 1'b1, addr_t[i] & 32'hFFFF_FFFC, be_t[i], wdata_t[i], 1'b0}) begin
            tests_failed++;
            $display("FAIL store%0d_req got req=%b we=%b addr=%h be=%b wdata=%h rdy=%b want 1 1 %h %b %h 0",
                     i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ex_ready,
                     addr_t[i] & 32'hFFFF_FFFC, be_t[i], wdata_t[i]);
         end
         tick();
         dmem_gnt = 1'b0;
         tests_run++;
         if ({dmem_req, reg_write_en, ex_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL store%0d_done got req=%b rwe=%b rdy=%b want 0 0 1", i, dmem_req, reg_write_en, ex_ready);
         end
      end
   endtask

   task automatic test_load();
      logic [31:0] addr_t  [6];
      logic [2:0]  f3_t    [6];
      logic [4:0]  rd_t    [6];
      logic [31:0] rdata_t [6];
      int          dly_t   [6];
      logic [31:0] exp_t   [6];
      logic        rwe_t   [6];
      addr_t[0] = 32'h2003; f3_t[0] = 3'b000; rd_t[0] = 5'd5; rdata_t[0] = 32'h80FF_0000; dly_t[0] = 2; exp_t[0] = 32'hFFFF_FF80; rwe_t[0] = 1'b1;
      addr_t[1] = 32'h2003; f3_t[1] = 3'b100; rd_t[1] = 5'd5; rdata_t[1] = 32'h80FF_0000; dly_t[1] = 2; exp_t[1] = 32'h0000_0080; rwe_t[1] = 1'b1;
      addr_t[2] = 32'h2002; f3_t[2] = 3'b001; rd_t[2] = 5'd6; rdata_t[2] = 32'h8001_1234; dly_t[2] = 0; exp_t[2] = 32'hFFFF_8001; rwe_t[2] = 1'b1;
      addr_t[3] = 32'h2000; f3_t[3] = 3'b101; rd_t[3] = 5'd6; rdata_t[3] = 32'h0000_9876; dly_t[3] = 0; exp_t[3] = 32'h0000_9876; rwe_t[3] = 1'b1;
      addr_t[4] = 32'h2004; f3_t[4] = 3'b010; rd_t[4] = 5'd7; rdata_t[4] = 32'h1357_9BDF; dly_t[4] = 1; exp_t[4] = 32'h1357_9BDF; rwe_t[4] = 1'b1;
      addr_t[5] = 32'h2008; f3_t[5] = 3'b010; rd_t[5] = 5'd0; rdata_t[5] = 32'hDEAD_BEEF; dly_t[5] = 0; exp_t[5] = 32'hDEAD_BEEF; rwe_t[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ex_valid = 1'b1; alu_result = addr_t[i]; funct3 = f3_t[i]; rd_addr_in = rd_t[i];
         reg_write_in = 1'b1; mem_read = 1'b1; mem_write = (i == 4); dmem_gnt = 1'b0;
         tick();
         ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
         for (int k = 0; k < dly_t[i]; k++) begin
            tests_run++;
            if (dmem_req !== 1'b1) begin
               tests_failed++;
               $display("FAIL load%0d_hold%0d got req=%b want 1", i, k, dmem_req);
            end
            tick();
         end
         tests_run++;
         if ({dmem_req, dmem_we, dmem_addr, ex_ready} !== {1'b1, 1'b0, addr_t[i] & 32'hFFFF_FFFC, 1'b0}) begin
            tests_failed++;
            $display("FAIL load%0d_req got req=%b we=%b addr=%h rdy=%b want 1 0 %h 0",
                     i, dmem_req, dmem_we, dmem_addr, ex_ready, addr_t[i] & 32'hFFFF_FFFC);
         end
         dmem_gnt = 1'b1;
         tick();
         dmem_gnt = 1'b0;
         tests_run++;
         if ({dmem_req, reg_write_en, ex_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL load%0d_wait got req=%b rwe=%b rdy=%b want 0 0 0", i, dmem_req, reg_write_en, ex_ready);
         end
         dmem_rvalid = 1'b1; dmem_rdata = rdata_t[i];
         tick();
         dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
         tests_run++;
         if ({reg_write_en, rd_addr, rd_data} !== {rwe_t[i], rd_t[i], exp_t[i]}) begin
            tests_failed++;
            $display("FAIL load%0d_wb got rwe=%b rd=%0d data=%h want %b %0d %h",
                     i, reg_write_en, rd_addr, rd_data, rwe_t[i], rd_t[i], exp_t[i]);
         end
         tick();
         tests_run++;
         if ({reg_write_en, ex_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL load%0d_end got rwe=%b rdy=%b want 0 1", i, reg_write_en, ex_ready);
         end
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] addr_t [3];
      logic [2:0]  f3_t   [3];
      logic        st_t   [3];
      addr_t[0] = 32'h2002; f3_t[0] = 3'b010; st_t[0] = 1'b0;
      addr_t[1] = 32'h2001; f3_t[1] = 3'b001; st_t[1] = 1'b0;
      addr_t[2] = 32'h1001; f3_t[2] = 3'b010; st_t[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_valid = 1'b1; alu_result = addr_t[i]; funct3 = f3_t[i]; rd_addr_in = 5'd8;
         reg_write_in = 1'b1; mem_read = !st_t[i]; mem_write = st_t[i]; dmem_gnt = 1'b1;
         tick();
         ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
         tests_run++;
         if ({misaligned, dmem_req, reg_write_en, ex_ready} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL mis%0d_pulse got mis=%b req=%b rwe=%b rdy=%b want 1 0 0 0",
                     i, misaligned, dmem_req, reg_write_en, ex_ready);
         end
         tick();
         dmem_gnt = 1'b0;
         tests_run++;
         if ({misaligned, dmem_req, reg_write_en, ex_ready} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mis%0d_end got mis=%b req=%b rwe=%b rdy=%b want 0 0 0 1",
                     i, misaligned, dmem_req, reg_write_en, ex_ready);
         end
      end
   endtask

   task automatic test_reset_in_wait();
      ex_valid = 1'b1; alu_result = 32'h3000; funct3 = 3'b010; rd_addr_in = 5'd10;
      reg_write_in = 1'b1; mem_read = 1'b1; dmem_gnt = 1'b1;
      tick();
      ex_valid = 1'b0; mem_read = 1'b0;
      tick();
      dmem_gnt = 1'b0;
      rst_n = 1'b0;
      #2;
      tests_run++;
      if ({dmem_req, reg_write_en, misaligned, rd_data} !== 35'h0) begin
         tests_failed++;
         $display("FAIL rstwait_during got req=%b rwe=%b mis=%b data=%h want 0 0 0 00000000",
                  dmem_req, reg_write_en, misaligned, rd_data);
      end
      tick();
      rst_n = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5_5A5A;
      tick();
      tests_run++;
      if ({ex_ready, dmem_req, reg_write_en, rd_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         tests_failed++;
         $display("FAIL rstwait_late_rvalid got rdy=%b req=%b rwe=%b data=%h want 1 0 0 00000000",
                  ex_ready, dmem_req, reg_write_en, rd_data);
      end
      dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      tick();
      tests_run++;
      if ({ex_ready, reg_write_en, rd_data} !== {1'b1, 1'b0, 32'h0}) begin
         tests_failed++;
         $display("FAIL rstwait_after got rdy=%b rwe=%b data=%h want 1 0 00000000", ex_ready, reg_write_en, rd_data);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      clear_inputs();
      #1;
      test_reset();
      test_alu();
      test_back_to_back();
      test_store();
      test_load();
      test_misaligned();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Downstream end of the execute stage: consumes the ALU result (address or value), the store data and the destination register.
- Performs the data-memory access over a req/gnt/rvalid handshake, formats load data, and drives the register-file write port (rd_addr, rd_data, reg_write_en).
- Stalls execute through ex_ready while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- ex_valid  in  1  execute presents an operation this cycle
- ex_ready  out  1  unit can accept; high only in IDLE
- alu_result  in  XLEN  ALU result; byte address for loads/stores
- rs2_data  in  XLEN  store data
- rd_addr_in  in  5  destination register
- reg_write_in  in  1  operation writes rd
- mem_read  in  1  load
- mem_write  in  1  store (mem_read and mem_write both high is illegal and treated as load)
- funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use [1:0]
- dmem_req  out  1  request to data memory
- dmem_we  out  1  write request
- dmem_addr  out  XLEN  word-aligned address ({alu_result[XLEN-1:2],2'b00})
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  read data
- rd_addr  out  5  register-file write address
- rd_data  out  XLEN  register-file write data
- reg_write_en  out  1  register-file write strobe, one-cycle pulse
- misaligned  out  1  one-cycle pulse on misaligned access

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except ex_ready=1 once rst_n=1. Any in-flight transaction is abandoned. A late dmem_rvalid after reset is ignored.
- Accept: ex_valid && ex_ready at a rising edge. Latch address, data, rd, funct3 and the control bits.
- States and transitions:
  - IDLE:
    - Non-memory op accepted: go to WB.
    - Memory op, aligned: go to REQ.
    - Memory op, misaligned: go to EXC.
  - REQ:
    - dmem_req=1; dmem_we, dmem_addr, dmem_wdata and dmem_be held stable until gnt.
    - gnt with load: go to WAIT.
    - gnt with store: go to IDLE.
  - WAIT: on dmem_rvalid, latch the formatted rdata and go to WB. rvalid in the same cycle as gnt is not legal; the memory returns data no earlier than the cycle after gnt.
  - WB: reg_write_en = reg_write_in && (rd != 0) for exactly one cycle; rd_data and rd_addr valid that cycle; then IDLE.
  - EXC: misaligned=1 for one cycle; no memory request and no writeback; then IDLE.
- Latency from accept edge:
  - ALU op: writeback 1 cycle after accept.
  - Load with gnt in the first REQ cycle and rvalid next cycle: writeback 3 cycles after accept.
  - Store: dmem_req high 1+ cycles, no writeback.
- Alignment rule by funct3[1:0]:
  - Half (01) needs addr[0]=0.
  - Word (10) needs addr[1:0]=00.
  - Byte (00) is always aligned.
- Store lanes (addr[1:0]=a):
  - Byte: be=0001<<a, wdata={4{rs2[7:0]}}.
  - Half: be=0011<<a, wdata={2{rs2[15:0]}}.
  - Word: be=1111, wdata=rs2.
- Load format: select byte or half at lane a, then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes through.
- x0 writes are always suppressed; rd_data is still driven.
- ex_ready is 0 in every state other than IDLE; back-to-back ALU ops therefore sustain one op per 2 cycles.

Decomposition:
- Shared package: funct3 load/store width encodings, the state enum (IDLE, REQ, WAIT, WB, EXC), and the byte-enable width constant.
- One natural sub-module: load_formatter (combinational: rdata, addr[1:0], funct3 -> extended XLEN result), reused later by a cache path.

Test Plan:
- ALU op: alu_result=0x0000_0008, rd=3, reg_write_in=1 -> reg_write_en pulse 1 cycle after accept, rd_addr=3, rd_data=0x8; dmem_req stays 0.
- SB to 0x1002 with rs2=0x1234_56AB, gnt same cycle -> dmem_addr=0x1000, be=0100, wdata=0xABAB_ABAB, dmem_we=1; no writeback; ex_ready back to 1.
- LB from 0x2003, rdata=0x80FF_0000, gnt delayed 2 cycles, rvalid 1 cycle later -> dmem_req held 3 cycles, rd_data=0xFFFF_FF80; LBU same access gives 0x0000_0080.
- LW to 0x2002 -> misaligned pulse, no dmem_req, no reg_write_en; LH to 0x2001 behaves the same.
- LW to rd=0 with rdata=0xDEAD_BEEF -> reg_write_en stays 0.
- rst_n dropped while in WAIT, then rvalid arrives -> outputs 0, ex_ready=1 after release, no writeback.
